// File: rtl/stream_packer.sv
// Mask-driven bit packer: compacts the selected sample bits and packs them LSB-first into full
// DW-bit words. Also provides a registered bypass, a zero-padding flush and an accumulator fill status.
module stream_packer #(
  parameter int unsigned DW = 32,
  parameter int unsigned FW = $clog2(DW) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ctl_ena,
  input  logic          ctl_clr,
  input  logic          ctl_flush,
  input  logic [DW-1:0] cfg_mask,
  input  logic [DW-1:0] sti_data,
  input  logic          sti_valid,
  output logic          sti_ready,
  output logic [DW-1:0] sto_data,
  output logic          sto_valid,
  input  logic          sto_ready,
  output logic [FW-1:0] sts_fill
);

  localparam int unsigned AW = 2 * DW - 1;
  localparam logic [FW:0] DwL = (FW + 1)'(DW);
  localparam logic [FW-1:0] OneL = FW'(1);

  logic [AW-1:0] r_acc, r_acc_d;
  logic [FW-1:0] r_fill, r_fill_d;
  logic [DW-1:0] r_out, r_out_d;
  logic          r_out_valid, r_out_valid_d;
  logic          r_flush_pend, r_flush_pend_d;

  logic [DW-1:0] w_comp;
  logic [FW-1:0] w_cnt;
  logic [AW-1:0] w_acc_or;
  logic [FW:0]   w_new;
  logic          w_full;
  logic          w_out_free;
  logic          w_in_fire;
  logic          w_out_fire;
  logic [DW-1:0] w_flush_word;

  // Gather the selected bits down to the bottom of w_comp, preserving order.
  always_comb begin
    w_comp = '0;
    w_cnt  = '0;
    for (int j = 0; j < DW; j++) begin
      if (cfg_mask[j]) begin
        w_comp = w_comp | (DW'(sti_data[j]) << w_cnt);
        w_cnt  = w_cnt + OneL;
      end
    end
  end

  assign w_acc_or     = r_acc | (AW'(w_comp) << r_fill);
  assign w_new        = {1'b0, r_fill} + {1'b0, w_cnt};
  assign w_full       = (w_new >= DwL);
  assign w_flush_word = r_acc[DW-1:0] & ~({DW{1'b1}} << r_fill);

  assign w_out_free = ~r_out_valid | sto_ready;
  assign sti_ready  = ~r_flush_pend & w_out_free;
  assign w_in_fire  = sti_valid & sti_ready;
  assign w_out_fire = r_out_valid & sto_ready;

  assign sto_data  = r_out;
  assign sto_valid = r_out_valid;
  assign sts_fill  = r_fill;

  always_comb begin
    r_acc_d        = r_acc;
    r_fill_d       = r_fill;
    r_out_d        = r_out;
    r_out_valid_d  = r_out_valid;
    r_flush_pend_d = r_flush_pend;

    if (w_out_fire) begin
      r_out_valid_d = 1'b0;
    end

    if (w_in_fire) begin
      if (!ctl_ena) begin
        r_out_d       = sti_data;
        r_out_valid_d = 1'b1;
      end else if (w_full) begin
        r_out_d       = w_acc_or[DW-1:0];
        r_out_valid_d = 1'b1;
        r_acc_d       = w_acc_or >> DW;
        r_fill_d      = FW'(w_new - DwL);
      end else begin
        r_acc_d  = w_acc_or;
        r_fill_d = w_new[FW-1:0];
      end
    end

    // No input can fire while a flush is pending, so this never collides with packing.
    if (r_flush_pend && w_out_free) begin
      r_flush_pend_d = 1'b0;
      if (ctl_ena && (r_fill != '0)) begin
        r_out_d       = w_flush_word;
        r_out_valid_d = 1'b1;
        r_acc_d       = '0;
        r_fill_d      = '0;
      end
    end

    if (ctl_flush) begin
      r_flush_pend_d = 1'b1;
    end

    if (ctl_clr) begin
      r_acc_d        = '0;
      r_fill_d       = '0;
      r_out_d        = '0;
      r_out_valid_d  = 1'b0;
      r_flush_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc        <= '0;
      r_fill       <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      r_acc        <= r_acc_d;
      r_fill       <= r_fill_d;
      r_out        <= r_out_d;
      r_out_valid  <= r_out_valid_d;
      r_flush_pend <= r_flush_pend_d;
    end
  end

endmodule
